// File: rtl/cache_line_allocator.sv
// ---------------------------------------------------------------------------
// cache_line_allocator
//
// Tracks which of the LINES cache lines are free. After reset it sweeps every
// line into the free state, one per cycle. It then hands out the lowest free
// line index, at most one per cycle, and accepts releases of busy lines.
// The registered free mask feeds the downstream cache_decider stage directly.
//
// Parameters are expected to satisfy 2**IDX_W >= LINES and 2**CNT_W > LINES.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   alloc_valid  requester wants one free line
//   alloc_ready  an allocation can be accepted this cycle
//   gnt_valid    one-cycle pulse, gnt_idx carries a fresh grant
//   gnt_idx      granted line index (holds while gnt_valid is low)
//   free_valid   release request
//   free_idx     line being released
//   bit_mask     registered free mask, bit i = 1 means line i is free
//   free_count   registered popcount of bit_mask
//   init_done    high once the init sweep has completed
//   err          sticky flag for an illegal release
//   err_clr      clears err (a concurrent illegal release wins)
// ---------------------------------------------------------------------------
module cache_line_allocator #(
    parameter int LINES = 20,
    parameter int IDX_W = 5,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    input  logic             free_valid,
    input  logic [IDX_W-1:0] free_idx,
    output logic [LINES-1:0] bit_mask,
    output logic [CNT_W-1:0] free_count,
    output logic             init_done,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam logic [LINES-1:0] ONE = {{(LINES-1){1'b0}}, 1'b1};

    state_t           state;
    logic [IDX_W-1:0] init_cnt;

    logic [IDX_W-1:0] sel;
    logic [LINES-1:0] fire_oh;
    logic [LINES-1:0] rel_oh;
    logic [LINES-1:0] init_oh;
    logic             rel_hit;
    logic             alloc_fire;
    logic             rel_legal;
    logic             rel_illegal;

    // Lowest free line, taken from the pre-edge mask so that a line being
    // released in the same cycle can never be granted in that cycle.
    always_comb begin
        sel = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (bit_mask[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    // A release hits only when free_idx names an existing line that is busy.
    // Out-of-range indices never match, so they fall out as illegal.
    always_comb begin
        rel_hit = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (free_idx == IDX_W'(i)) begin
                rel_hit = ~bit_mask[i];
            end
        end
    end

    assign alloc_ready = (state == READY) && (free_count != '0);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign rel_legal   = (state == READY) && free_valid && rel_hit;
    assign rel_illegal = (state == READY) && free_valid && !rel_hit;

    assign fire_oh = alloc_fire ? (ONE << sel) : '0;
    assign rel_oh  = rel_legal ? (ONE << free_idx) : '0;
    assign init_oh = ONE << init_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            bit_mask   <= '0;
            free_count <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            init_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    gnt_valid  <= 1'b0;
                    bit_mask   <= bit_mask | init_oh;
                    free_count <= free_count + CNT_W'(1);
                    init_cnt   <= init_cnt + IDX_W'(1);
                    if (init_cnt == IDX_W'(LINES - 1)) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    // Granted and released bits are disjoint (set vs clear),
                    // so both updates can be merged into one mask write.
                    bit_mask  <= (bit_mask & ~fire_oh) | rel_oh;
                    gnt_valid <= alloc_fire;
                    if (alloc_fire) begin
                        gnt_idx <= sel;
                    end
                    case ({alloc_fire, rel_legal})
                        2'b10:   free_count <= free_count - CNT_W'(1);
                        2'b01:   free_count <= free_count + CNT_W'(1);
                        default: free_count <= free_count;
                    endcase
                end
                default: begin
                    state <= INIT;
                end
            endcase

            if (rel_illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_allocator.sv
// ---------------------------------------------------------------------------
// tb_cache_line_allocator
//
// Directed bench for cache_line_allocator. A small behavioural model predicts
// the free mask, counter, error flag and grants. Expected grant indices are
// queued when a handshake is driven and popped when the grant appears.
// ---------------------------------------------------------------------------
module tb_cache_line_allocator;

    localparam int LINES = 20;
    localparam int IDX_W = 5;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_valid = 1'b0;
    logic             free_valid = 1'b0;
    logic [IDX_W-1:0] free_idx = '0;
    logic             err_clr = 1'b0;
    logic             alloc_ready;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [LINES-1:0] bit_mask;
    logic [CNT_W-1:0] free_count;
    logic             init_done;
    logic             err;

    cache_line_allocator #(
        .LINES(LINES),
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .free_valid (free_valid),
        .free_idx   (free_idx),
        .bit_mask   (bit_mask),
        .free_count (free_count),
        .init_done  (init_done),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [IDX_W-1:0] exp_q[$];

    // Reference model state
    logic [LINES-1:0] m_mask;
    int               m_cnt;
    int               m_icnt;
    bit               m_init;
    bit               m_done;
    bit               m_err;
    bit               m_gv;
    logic [IDX_W-1:0] m_gidx;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IDX_W-1:0] lowest(input logic [LINES-1:0] mask);
        for (int i = 0; i < LINES; i++) begin
            if (mask[i]) return IDX_W'(i);
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_mask = '0;
        m_cnt  = 0;
        m_icnt = 0;
        m_init = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_gv   = 1'b0;
        m_gidx = '0;
        exp_q.delete();
    endtask

    // Predicts the effect of the upcoming clock edge from the current inputs.
    task automatic model_step();
        bit               hs;
        bit               legal;
        logic [IDX_W-1:0] sel;
        if (!rst_n) begin
            model_reset();
        end else if (m_init) begin
            m_gv = 1'b0;
            m_mask[m_icnt] = 1'b1;
            m_cnt++;
            if (m_icnt == LINES - 1) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
            m_icnt++;
            if (err_clr) m_err = 1'b0;
        end else begin
            hs    = alloc_valid && (m_cnt != 0);
            legal = free_valid && (int'(free_idx) < LINES) && (m_mask[free_idx] == 1'b0);
            m_gv  = hs;
            if (hs) begin
                sel = lowest(m_mask);
                exp_q.push_back(sel);
                m_mask[sel] = 1'b0;
                m_cnt--;
            end
            if (legal) begin
                m_mask[free_idx] = 1'b1;
                m_cnt++;
            end
            if (free_valid && !legal) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [IDX_W-1:0] exp_idx;
        checkOutput("gnt_valid", 32'(gnt_valid), 32'(m_gv));
        if (m_gv) begin
            exp_idx = exp_q.pop_front();
            checkOutput("gnt_idx", 32'(gnt_idx), 32'(exp_idx));
            m_gidx = exp_idx;
        end else begin
            checkOutput("gnt_idx_hold", 32'(gnt_idx), 32'(m_gidx));
        end
        checkOutput("bit_mask", 32'(bit_mask), 32'(m_mask));
        checkOutput("free_count", 32'(free_count), 32'(m_cnt));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("init_done", 32'(init_done), 32'(m_done));
        checkOutput("alloc_ready", 32'(alloc_ready), 32'(m_done && (m_cnt != 0)));
    endtask

    // Drives one cycle of inputs, advances the model, then checks outputs
    // one time unit after the rising edge.
    task automatic applyStimulus(input bit av, input bit fv, input logic [IDX_W-1:0] fi, input bit ec);
        alloc_valid = av;
        free_valid  = fv;
        free_idx    = fi;
        err_clr     = ec;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Counter/mask consistency, checked every cycle on the falling edge.
    always @(negedge clk) begin
        checkOutput("popcount", 32'(free_count), 32'($countones(bit_mask)));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [IDX_W-1:0] rel_list[8];
        rel_list = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};

        model_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        compare_all();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);

        // Init sweep with a request held the whole time
        rst_n = 1'b1;
        for (int c = 0; c < LINES; c++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        end
        checkOutput("init_mask", 32'(bit_mask), 32'h000FFFFF);
        checkOutput("init_count", 32'(free_count), 32'd20);
        checkOutput("init_done_set", 32'(init_done), 32'd1);

        // Drain all lines, then one refused request
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("first_grant", 32'(gnt_idx), 32'd0);
        for (int c = 1; c < LINES + 1; c++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        end
        checkOutput("empty_mask", 32'(bit_mask), 32'd0);
        checkOutput("empty_count", 32'(free_count), 32'd0);
        checkOutput("empty_ready", 32'(alloc_ready), 32'd0);
        checkOutput("empty_no_grant", 32'(gnt_valid), 32'd0);

        // Release while empty and requesting
        applyStimulus(1'b1, 1'b1, 5'd7, 1'b0);
        checkOutput("free7_mask", 32'(bit_mask), 32'h00000080);
        checkOutput("free7_no_grant", 32'(gnt_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("grant7", 32'(gnt_idx), 32'd7);

        // Simultaneous allocate and legal release
        applyStimulus(1'b0, 1'b1, 5'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b0);
        checkOutput("mask_c", 32'(bit_mask), 32'h0000000C);
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b0);
        checkOutput("simul_grant", 32'(gnt_idx), 32'd2);
        checkOutput("simul_mask", 32'(bit_mask), 32'h00000028);
        checkOutput("simul_count", 32'(free_count), 32'd2);

        // Build a mid-stream mask, then reset asynchronously
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        foreach (rel_list[k]) begin
            applyStimulus(1'b0, 1'b1, rel_list[k], 1'b0);
        end
        checkOutput("mid_mask", 32'(bit_mask), 32'h0000F0F0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("pre_reset_gnt", 32'(gnt_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        checkOutput("async_gnt_drop", 32'(gnt_valid), 32'd0);
        checkOutput("async_mask", 32'(bit_mask), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

        // Sweep again; releases during the sweep must be ignored silently
        rst_n = 1'b1;
        for (int c = 0; c < LINES; c++) begin
            applyStimulus(1'b1, 1'b1, 5'd3, 1'b0);
        end
        checkOutput("reinit_mask", 32'(bit_mask), 32'h000FFFFF);
        checkOutput("reinit_err", 32'(err), 32'd0);

        // Illegal releases and error clearing
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b0);
        checkOutput("err_dup", 32'(err), 32'd1);
        checkOutput("err_dup_mask", 32'(bit_mask), 32'h000FFFFF);
        applyStimulus(1'b0, 1'b1, 5'd25, 1'b0);
        checkOutput("err_range_count", 32'(free_count), 32'd20);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("err_sticky", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("err_cleared", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1);
        checkOutput("err_priority", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);

        // Allocation proceeds alongside an illegal release
        applyStimulus(1'b1, 1'b1, 5'd25, 1'b0);
        checkOutput("alloc_with_bad_free", 32'(gnt_idx), 32'd0);
        checkOutput("alloc_with_bad_err", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
